// File: rtl/atm_pkg.sv
// ATM package: state encoding, default account constants and a helper that
// sizes the wrong-PIN counter.
package atm_pkg;

    // Transaction FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERIFY = 3'd1,
        CHECK  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4,
        LOCKED = 3'd5
    } state_t;

    // Default account PIN.
    localparam logic [4:0] DEFAULT_PIN_CODE     = 5'd18;
    // Default balance after reset.
    localparam logic [7:0] DEFAULT_INIT_BALANCE = 8'd200;
    // Default number of wrong-PIN attempts in a row that lock the machine.
    localparam int         DEFAULT_MAX_TRIES    = 3;

    // Bits needed to count from 0 up to maxTries.
    // The result is kept at least 1 so the counter never collapses to zero
    // width.
    function automatic int failCountWidth(input int maxTries);
        return (maxTries < 1) ? 1 : $clog2(maxTries + 1);
    endfunction

endpackage

// File: rtl/atm.sv
// ATM controller. A transaction is requested by face recognition.
// The machine checks the PIN captured at the start of the transaction, then
// the balance, and then debits the account. Too many wrong PINs in a row lock
// it until reset. Every output comes straight from a register.
module atm
    import atm_pkg::*;
#(
    parameter logic [4:0] PIN_CODE     = DEFAULT_PIN_CODE,
    parameter logic [7:0] INIT_BALANCE = DEFAULT_INIT_BALANCE,
    parameter int         MAX_TRIES    = DEFAULT_MAX_TRIES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] pin,
    input  logic [7:0] amount,
    input  logic       face,
    output logic [7:0] old_balance,
    output logic [7:0] new_balance,
    output logic       mini_statement
);

    localparam int          CW        = failCountWidth(MAX_TRIES);
    localparam logic [CW-1:0] TRY_LIMIT = CW'(MAX_TRIES);

    state_t        r_state;
    logic [4:0]    r_pin;
    logic [7:0]    r_amount;
    logic [7:0]    r_balance;
    logic [CW-1:0] r_failCnt;
    logic [7:0]    r_oldBalance;
    logic [7:0]    r_newBalance;
    logic          r_mini;

    state_t        w_nextState;
    logic          w_capture;
    logic [7:0]    w_nextBalance;
    logic [7:0]    w_nextOld;
    logic [7:0]    w_nextNew;
    logic          w_nextMini;
    logic [CW-1:0] w_nextFail;
    logic [CW-1:0] w_failInc;

    assign w_failInc = r_failCnt + CW'(1);

    // State register. Reset is asynchronous so that a transaction in progress is abandoned at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and next datapath values. The current values are the defaults, so only the transitions below change anything.
    always_comb begin
        w_nextState   = r_state;
        w_capture     = 1'b0;
        w_nextBalance = r_balance;
        w_nextOld     = r_oldBalance;
        w_nextNew     = r_newBalance;
        w_nextMini    = 1'b0;
        w_nextFail    = r_failCnt;

        case (r_state)
            IDLE: begin
                if (face) begin
                    w_capture   = 1'b1;
                    w_nextState = VERIFY;
                end
            end

            VERIFY: begin
                if (r_pin == PIN_CODE) begin
                    w_nextFail  = '0;
                    w_nextState = CHECK;
                end else begin
                    w_nextFail = w_failInc;
                    if (w_failInc >= TRY_LIMIT) begin
                        w_nextState = LOCKED;
                    end else begin
                        w_nextState = DONE;
                    end
                end
            end

            CHECK: begin
                if (r_amount <= r_balance) begin
                    w_nextState = UPDATE;
                end else begin
                    w_nextOld   = r_balance;
                    w_nextNew   = r_balance;
                    w_nextState = DONE;
                end
            end

            UPDATE: begin
                w_nextOld     = r_balance;
                w_nextBalance = r_balance - r_amount;
                w_nextNew     = r_balance - r_amount;
                w_nextMini    = 1'b1;
                w_nextState   = DONE;
            end

            DONE: begin
                if (!face) begin
                    w_nextState = IDLE;
                end
            end

            LOCKED: begin
                w_nextState = LOCKED;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Latch the PIN and amount when a transaction starts. Later changes on the inputs do not affect a running transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pin    <= '0;
            r_amount <= '0;
        end else if (w_capture) begin
            r_pin    <= pin;
            r_amount <= amount;
        end
    end

    // Account balance, wrong-PIN count and the registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_balance    <= INIT_BALANCE;
            r_failCnt    <= '0;
            r_oldBalance <= 8'd0;
            r_newBalance <= INIT_BALANCE;
            r_mini       <= 1'b0;
        end else begin
            r_balance    <= w_nextBalance;
            r_failCnt    <= w_nextFail;
            r_oldBalance <= w_nextOld;
            r_newBalance <= w_nextNew;
            r_mini       <= w_nextMini;
        end
    end

    assign old_balance    = r_oldBalance;
    assign new_balance    = r_newBalance;
    assign mini_statement = r_mini;

endmodule

// File: tb/tb_atm.sv
// Testbench for the ATM controller.
// A transaction-level account model is driven by directed scenarios, then by
// randomized traffic.
module tb_atm;

    localparam int PIN_OK     = 18;
    localparam int START_BAL  = 200;
    localparam int TRY_LIMIT  = 3;

    logic       clk;
    logic       rst;
    logic [4:0] pin;
    logic [7:0] amount;
    logic       face;
    logic [7:0] old_balance;
    logic [7:0] new_balance;
    logic       mini_statement;

    int checkCount;
    int errorCount;

    // Reference account state, tracked one whole transaction at a time.
    int mBalance;
    int mOld;
    int mNew;
    int mFails;
    bit mLocked;

    atm dut (
        .clk            (clk),
        .rst            (rst),
        .pin            (pin),
        .amount         (amount),
        .face           (face),
        .old_balance    (old_balance),
        .new_balance    (new_balance),
        .mini_statement (mini_statement)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and report any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Put the model back into its post-reset state.
    task automatic modelReset();
        mBalance = START_BAL;
        mOld     = 0;
        mNew     = START_BAL;
        mFails   = 0;
        mLocked  = 1'b0;
    endtask

    // Assert reset, check the outputs while reset is held, then release it.
    task automatic resetDut();
        @(negedge clk);
        face = 1'b0;
        rst  = 1'b0;
        #1;
        modelReset();
        checkOutput("reset old_balance", old_balance, mOld);
        checkOutput("reset new_balance", new_balance, mNew);
        checkOutput("reset mini", mini_statement, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Run one full transaction. Face is held high for `hold` edges.
    // The mini-statement pulse is checked on every cycle, and the balances
    // are checked after face is dropped.
    task automatic applyStimulus(input logic [4:0] p, input logic [7:0] a, input int hold);
        bit expectPulse;
        expectPulse = 1'b0;
        if (!mLocked) begin
            if (int'(p) != PIN_OK) begin
                mFails++;
                if (mFails >= TRY_LIMIT) mLocked = 1'b1;
            end else begin
                mFails = 0;
                mOld   = mBalance;
                if (int'(a) <= mBalance) begin
                    mBalance    = mBalance - int'(a);
                    expectPulse = 1'b1;
                end
                mNew = mBalance;
            end
        end

        @(negedge clk);
        pin    = p;
        amount = a;
        face   = 1'b1;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                pin    = 5'($urandom);
                amount = 8'($urandom);
            end
            checkOutput("mini pulse", mini_statement, (expectPulse && k == 4) ? 1 : 0);
        end
        @(negedge clk);
        face = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mini idle", mini_statement, 0);
        checkOutput("old_balance", old_balance, mOld);
        checkOutput("new_balance", new_balance, mNew);
    endtask

    // Pull reset while the machine is in UPDATE. This must abort the debit.
    task automatic resetDuringUpdate();
        @(negedge clk);
        pin    = 5'(PIN_OK);
        amount = 8'd30;
        face   = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("abort old_balance", old_balance, 0);
        checkOutput("abort new_balance", new_balance, START_BAL);
        checkOutput("abort mini", mini_statement, 0);
        face = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(5'(PIN_OK), 8'd201, 6);
    endtask

    // Directed scenarios first, then randomized transactions with occasional resets.
    initial begin
        int nTrans;
        logic [4:0] rp;
        logic [7:0] ra;
        checkCount = 0;
        errorCount = 0;
        rst    = 1'b0;
        pin    = '0;
        amount = '0;
        face   = 1'b0;
        modelReset();

        resetDut();
        applyStimulus(5'd18, 8'd232, 6);
        applyStimulus(5'd18, 8'd50, 9);
        applyStimulus(5'd18, 8'd150, 6);
        applyStimulus(5'd18, 8'd1, 6);

        resetDut();
        repeat (3) applyStimulus(5'd5, 8'd10, 6);
        applyStimulus(5'd18, 8'd10, 7);
        resetDut();

        applyStimulus(5'd7, 8'd20, 6);
        applyStimulus(5'd9, 8'd20, 6);
        applyStimulus(5'd18, 8'd20, 6);
        applyStimulus(5'd1, 8'd5, 6);
        applyStimulus(5'd2, 8'd5, 6);
        applyStimulus(5'd18, 8'd0, 6);
        applyStimulus(5'd18, 8'd160, 6);

        resetDuringUpdate();

        nTrans = 40;
        for (int t = 0; t < nTrans; t++) begin
            if ($urandom_range(0, 9) == 0) resetDut();
            rp = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(PIN_OK);
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 60));
            applyStimulus(rp, ra, 6 + int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
